// File: rtl/fft_stream_r2.sv
// Streaming radix-2 DIT FFT/IFFT: bit-reversed load, in-place butterflies
// (one per clock), then natural-order unload with backpressure.
module fft_stream_r2 #(
    parameter int W     = 16,
    parameter int N     = 8,
    parameter int SCALE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [W-1:0]         in_real,
    input  logic signed [W-1:0]         in_imag,
    input  logic                        in_inverse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [W-1:0]         out_real,
    output logic signed [W-1:0]         out_imag,
    output logic [$clog2(N)-1:0]        out_index,
    output logic                        out_last,
    output logic                        busy
);
    // state   | meaning
    // LOAD    | accepting samples into bit-reversed addresses
    // COMPUTE | one butterfly per clock, log2(N) stages of N/2
    // UNLOAD  | presenting bins in natural order
    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

    localparam int  LOG = $clog2(N);
    localparam real PI  = 3.14159265358979323846;
    localparam logic signed [2*W:0] RND  = (2*W+1)'(1) <<< (W-2);
    localparam logic signed [W+1:0] SMAX = (W+2)'((1 << (W-1)) - 1);
    localparam logic signed [W+1:0] SMIN = (W+2)'(-(1 << (W-1)));

    state_t state_q, state_d;

    logic signed [W-1:0] re_q [N];
    logic signed [W-1:0] im_q [N];
    logic [LOG-1:0]      load_cnt_q;
    logic [LOG-1:0]      idx_q;
    logic [LOG-1:0]      stage_q;
    logic [LOG-2:0]      bfly_q;
    logic                inv_q;

    function automatic logic signed [W-1:0] q_rom(input real v);
        real s, r;
        s = v * (2.0 ** (W-1));
        r = (s >= 0.0) ? $floor(s + 0.5) : -$floor(0.5 - s);
        if (r > (2.0 ** (W-1)) - 1.0) r = (2.0 ** (W-1)) - 1.0;
        return W'($rtoi(r));
    endfunction

    function automatic logic [LOG-1:0] bitrev(input logic [LOG-1:0] v);
        logic [LOG-1:0] r;
        for (int i = 0; i < LOG; i++) r[i] = v[LOG-1-i];
        return r;
    endfunction

    function automatic logic signed [2*W-1:0] sx(input logic signed [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        if (v > SMAX) return SMAX[W-1:0];
        if (v < SMIN) return SMIN[W-1:0];
        return v[W-1:0];
    endfunction

    // Forward twiddle is cos - j*sin; the sin table is negated for forward mode.
    logic signed [W-1:0] tw_c [N/2];
    logic signed [W-1:0] tw_s [N/2];
    for (genvar k = 0; k < N/2; k++) begin : g_tw
        localparam logic signed [W-1:0] C_K = q_rom($cos(2.0 * PI * k / N));
        localparam logic signed [W-1:0] S_K = q_rom($sin(2.0 * PI * k / N));
        assign tw_c[k] = C_K;
        assign tw_s[k] = S_K;
    end

    logic [LOG-1:0]      jx, half, mask, top, bot;
    logic [LOG-2:0]      tw_k;
    logic signed [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [2*W-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [2*W:0] p_re_f, p_im_f;
    logic signed [W+1:0] p_re, p_im, add_re, add_im, sub_re, sub_im;
    logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im;
    logic                last_stage, last_bfly;

    always_comb begin
        jx   = {1'b0, bfly_q};
        half = LOG'(1) << stage_q;
        mask = half - LOG'(1);
        top  = ((jx >> stage_q) << (stage_q + 1'b1)) | (jx & mask);
        bot  = top | half;
        tw_k = (LOG-1)'((jx & mask) << (LOG - 1 - int'(stage_q)));

        a_re = re_q[top];
        a_im = im_q[top];
        b_re = re_q[bot];
        b_im = im_q[bot];
        w_re = tw_c[tw_k];
        w_im = inv_q ? tw_s[tw_k] : -tw_s[tw_k];

        m_rr = sx(b_re) * sx(w_re);
        m_ii = sx(b_im) * sx(w_im);
        m_ri = sx(b_re) * sx(w_im);
        m_ir = sx(b_im) * sx(w_re);
        p_re_f = {m_rr[2*W-1], m_rr} - {m_ii[2*W-1], m_ii} + RND;
        p_im_f = {m_ri[2*W-1], m_ri} + {m_ir[2*W-1], m_ir} + RND;
        p_re = (W+2)'(p_re_f >>> (W-1));
        p_im = (W+2)'(p_im_f >>> (W-1));

        add_re = {{2{a_re[W-1]}}, a_re} + p_re;
        add_im = {{2{a_im[W-1]}}, a_im} + p_im;
        sub_re = {{2{a_re[W-1]}}, a_re} - p_re;
        sub_im = {{2{a_im[W-1]}}, a_im} - p_im;
        if (SCALE != 0) begin
            add_re = add_re >>> 1;
            add_im = add_im >>> 1;
            sub_re = sub_re >>> 1;
            sub_im = sub_im >>> 1;
        end
        y0_re = sat(add_re);
        y0_im = sat(add_im);
        y1_re = sat(sub_re);
        y1_im = sat(sub_im);

        last_stage = (stage_q == LOG'(LOG-1));
        last_bfly  = (bfly_q == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (in_valid && load_cnt_q == LOG'(N-1)) state_d = ST_COMPUTE;
            ST_COMPUTE: if (last_stage && last_bfly)             state_d = ST_UNLOAD;
            ST_UNLOAD:  if (out_ready && idx_q == LOG'(N-1))     state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        busy      = (state_q != ST_LOAD);
        out_valid = (state_q == ST_UNLOAD);
        out_index = idx_q;
        out_last  = out_valid && (idx_q == LOG'(N-1));
        out_real  = out_valid ? re_q[idx_q] : '0;
        out_imag  = out_valid ? im_q[idx_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
            load_cnt_q <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            bfly_q     <= '0;
            inv_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: if (in_valid) begin
                    re_q[bitrev(load_cnt_q)] <= in_real;
                    im_q[bitrev(load_cnt_q)] <= in_imag;
                    load_cnt_q <= load_cnt_q + 1'b1;
                    if (load_cnt_q == '0) inv_q <= in_inverse;
                end
                ST_COMPUTE: begin
                    re_q[top] <= y0_re;
                    im_q[top] <= y0_im;
                    re_q[bot] <= y1_re;
                    im_q[bot] <= y1_im;
                    bfly_q    <= bfly_q + 1'b1;
                    if (last_bfly) stage_q <= last_stage ? '0 : stage_q + 1'b1;
                end
                ST_UNLOAD: if (out_ready) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
